// File: rtl/safe_cracker.sv
// Safe cracker: recovers a 10-bit code one bit at a time from popcount hints, then
// submits it and waits for the lock to open, retrying up to MAX_TRIES passes.
module safe_cracker #(
   parameter int SETTLE    = 2,
   parameter int LOCK_WAIT = 8,
   parameter int MAX_TRIES = 3
) (
   input  logic       MAX10_CLK1_50,
   input  logic       RESETN,
   input  logic       START,
   input  logic [3:0] HINT,
   input  logic       LOCKED,
   output logic [9:0] GUESS,
   output logic       ENTER,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [3:0] TRIES
);

   typedef enum logic [3:0] {
      S_IDLE, S_BASE, S_FLIP, S_WAIT, S_JUDGE, S_SUBMIT, S_LOCKWAIT, S_DONE, S_FAIL
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_WAIT - 1);
   localparam logic [3:0] TRIES_MAX   = 4'(MAX_TRIES);

   state_t     r_state, w_next;
   logic [9:0] r_guess;
   logic [3:0] r_idx, r_href, r_hnew, r_tries;
   logic [7:0] r_cnt;

   logic       w_settled, w_keep, w_revert, w_scan_end, w_lock_expired;
   logic       w_timeout, w_retry_fail;
   logic [3:0] w_href_next, w_tries_inc;

   // href is never 0 in JUDGE: a zero hint always routes straight to SUBMIT.
   assign w_settled      = (r_cnt == SETTLE_LAST);
   assign w_keep         = (r_hnew == r_href - 4'd1);
   assign w_revert       = (r_hnew == r_href + 4'd1);
   assign w_href_next    = w_keep ? r_hnew : r_href;
   assign w_scan_end     = (w_href_next == 4'd0) || (r_idx == 4'd9);
   assign w_lock_expired = LOCKED && (r_cnt == LOCK_LAST);
   assign w_timeout      = ((r_state == S_JUDGE) && !w_keep && !w_revert) ||
                           ((r_state == S_LOCKWAIT) && w_lock_expired);
   assign w_tries_inc    = r_tries + 4'd1;
   assign w_retry_fail   = (w_tries_inc == TRIES_MAX);

   // NOTE: async reset in the sensitivity list, and <= for every register so all
   // state updates see pre-edge values regardless of statement order.
   always_ff @(posedge MAX10_CLK1_50 or negedge RESETN) begin
      if (!RESETN) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:     if (START) w_next = S_BASE;
         S_BASE:     if (w_settled) w_next = !(|HINT) ? S_SUBMIT : S_FLIP;
         S_FLIP:     w_next = S_WAIT;
         S_WAIT:     if (w_settled) w_next = S_JUDGE;
         S_JUDGE:    if (w_timeout)       w_next = w_retry_fail ? S_FAIL : S_BASE;
                     else if (w_scan_end) w_next = S_SUBMIT;
                     else                 w_next = S_FLIP;
         S_SUBMIT:   w_next = S_LOCKWAIT;
         S_LOCKWAIT: if (!LOCKED)        w_next = S_DONE;
                     else if (w_timeout) w_next = w_retry_fail ? S_FAIL : S_BASE;
         S_DONE,
         S_FAIL:     if (!START) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge RESETN) begin
      if (!RESETN) begin
         r_guess <= '0;
         r_idx   <= '0;
         r_href  <= '0;
         r_hnew  <= '0;
         r_tries <= '0;
         r_cnt   <= '0;
      end else begin
         // Counter restarts on every state change and only runs in timed states.
         if ((w_next == r_state) && (r_state inside {S_BASE, S_WAIT, S_LOCKWAIT}))
            r_cnt <= r_cnt + 8'd1;
         else
            r_cnt <= '0;

         unique case (r_state)
            S_IDLE: begin
               r_guess <= '0;
               if (START) begin
                  r_idx   <= '0;
                  r_href  <= '0;
                  r_tries <= '0;
               end
            end
            S_BASE: if (w_settled) r_href <= HINT;
            S_FLIP: r_guess[r_idx] <= ~r_guess[r_idx];
            S_WAIT: if (w_settled) r_hnew <= HINT;
            S_JUDGE: begin
               if (w_timeout) begin
                  r_tries <= w_tries_inc;
                  if (!w_retry_fail) begin
                     r_guess <= '0;
                     r_idx   <= '0;
                  end
               end else begin
                  r_href <= w_href_next;
                  if (w_revert) r_guess[r_idx] <= ~r_guess[r_idx];
                  if (!w_scan_end) r_idx <= r_idx + 4'd1;
               end
            end
            S_LOCKWAIT: begin
               if (w_timeout) begin
                  r_tries <= w_tries_inc;
                  if (!w_retry_fail) begin
                     r_guess <= '0;
                     r_idx   <= '0;
                  end
               end
            end
            S_DONE,
            S_FAIL: if (!START) r_guess <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      ENTER = (r_state == S_SUBMIT);
      BUSY  = !(r_state inside {S_IDLE, S_DONE, S_FAIL});
      DONE  = (r_state == S_DONE);
      FAIL  = (r_state == S_FAIL);
   end

   assign GUESS = r_guess;
   assign TRIES = r_tries;

endmodule

// File: tb/tb_safe_cracker.sv
// Bench for safe_cracker: a behavioural safe that returns a delayed popcount hint and
// unlocks on a matching ENTER drives the DUT; expectations come from the code and search rules.
module tb_safe_cracker;
   localparam int SETTLE    = 2;
   localparam int LOCK_WAIT = 8;
   localparam int MAX_TRIES = 3;
   localparam int STEP      = SETTLE + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] safe_hint;
   logic       locked = 1'b1;
   logic [9:0] guess;
   logic       enter, busy, done, fail;
   logic [3:0] tries;

   int vectors = 0;
   int errors  = 0;

   logic [9:0] pw = '0;
   logic [9:0] g_d = '0;
   bit         stuck_mode = 1'b0;
   bit         never_unlock = 1'b0;
   bit         relock = 1'b0;
   int         enter_cnt = 0;

   safe_cracker #(.SETTLE(SETTLE), .LOCK_WAIT(LOCK_WAIT), .MAX_TRIES(MAX_TRIES)) dut (
      .MAX10_CLK1_50(clk), .RESETN(rst_n), .START(start), .HINT(safe_hint), .LOCKED(locked),
      .GUESS(guess), .ENTER(enter), .BUSY(busy), .DONE(done), .FAIL(fail), .TRIES(tries)
   );

   always #5 clk = ~clk;

   // Safe model: hint lags GUESS by SETTLE-1 registers; stuck mode freezes the first-pass hint.
   always @(posedge clk) g_d <= guess;
   assign safe_hint = (stuck_mode && tries == 4'd0 && g_d != 10'd0) ? 4'($countones(pw))
                                                                    : 4'($countones(g_d ^ pw));

   always @(posedge clk) begin
      if (relock) begin
         locked    <= 1'b1;
         enter_cnt <= 0;
      end else if (enter) begin
         enter_cnt <= enter_cnt + 1;
         if (guess == pw && !never_unlock) locked <= 1'b0;
      end
   end

   function automatic int scan_len(input logic [9:0] p);
      int n = 0;
      for (int i = 0; i < 10; i++) if (p[i]) n = i + 1;
      return n;
   endfunction

   function automatic int enter_latency(input logic [9:0] p);
      return SETTLE + 1 + scan_len(p) * STEP;
   endfunction

   task automatic init_safe(input logic [9:0] p, input bit stuck, input bit never);
      pw = p; stuck_mode = stuck; never_unlock = never;
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
   endtask

   // Counts negedges until ENTER is seen and gathers every GUESS bit that was ever high.
   task automatic wait_enter(output int k, output logic [9:0] seen);
      k = 0; seen = '0;
      do begin
         @(negedge clk);
         k++;
         seen |= guess;
      end while (!enter && k < 1000);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || fail) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!(done || fail)) begin
         errors++;
         $display("FAIL end_timeout: no DONE/FAIL after %0d cycles", n);
      end
   endtask

   task automatic go_idle();
      start = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || guess !== 10'd0) begin
         errors++;
         $display("FAIL idle: busy=%b done=%b fail=%b guess=%b, want 0 0 0 0", busy, done, fail, guess);
      end
   endtask

   task automatic check_success(input string name, input int exp_tries);
      vectors++;
      if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s flags: done=%b fail=%b busy=%b want 1 0 0", name, done, fail, busy);
      end
      vectors++;
      if (guess !== pw) begin
         errors++;
         $display("FAIL %s guess: got %b want %b", name, guess, pw);
      end
      vectors++;
      if (enter_cnt !== 1) begin
         errors++;
         $display("FAIL %s enters: got %0d want 1", name, enter_cnt);
      end
      vectors++;
      if (tries !== 4'(exp_tries)) begin
         errors++;
         $display("FAIL %s tries: got %0d want %0d", name, tries, exp_tries);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({guess, enter, busy, done, fail, tries} !== '0) begin
         errors++;
         $display("FAIL reset: guess=%b enter=%b busy=%b done=%b fail=%b tries=%0d want all 0",
                  guess, enter, busy, done, fail, tries);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_search(input logic [9:0] p, input string name);
      int k; logic [9:0] seen; logic [10:0] mask;
      init_safe(p, 1'b0, 1'b0);
      start = 1'b1;
      wait_enter(k, seen);
      vectors++;
      if (k !== enter_latency(p)) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, k, enter_latency(p));
      end
      mask = (11'd1 << scan_len(p)) - 11'd1;
      vectors++;
      if ((seen & ~mask[9:0]) !== 10'd0) begin
         errors++;
         $display("FAIL %s scan: toggled %b beyond mask %b", name, seen, mask[9:0]);
      end
      wait_end();
      repeat (2) @(negedge clk);
      check_success(name, 0);
      go_idle();
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) test_search(10'($urandom_range(0, 1023)), "random");
   endtask

   task automatic test_lock_fail();
      init_safe(10'($urandom_range(1, 1023)), 1'b0, 1'b1);
      start = 1'b1;
      wait_end();
      vectors++;
      if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || tries !== 4'(MAX_TRIES)) begin
         errors++;
         $display("FAIL lock_fail: fail=%b done=%b busy=%b tries=%0d want 1 0 0 %0d",
                  fail, done, busy, tries, MAX_TRIES);
      end
      vectors++;
      if (enter_cnt !== MAX_TRIES) begin
         errors++;
         $display("FAIL lock_fail enters: got %0d want %0d", enter_cnt, MAX_TRIES);
      end
      go_idle();
      vectors++;
      if (tries !== 4'(MAX_TRIES)) begin
         errors++;
         $display("FAIL lock_fail idle tries: got %0d want %0d", tries, MAX_TRIES);
      end
   endtask

   task automatic test_inconsistent();
      init_safe(10'($urandom_range(1, 1023)), 1'b1, 1'b0);
      start = 1'b1;
      wait_end();
      check_success("inconsistent", 1);
      go_idle();
      vectors++;
      if (tries !== 4'd1) begin
         errors++;
         $display("FAIL idle_tries_hold: got %0d want 1", tries);
      end
      init_safe(10'($urandom_range(0, 1023)), 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      vectors++;
      if (tries !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL tries_clear: tries=%0d busy=%b want 0 1", tries, busy);
      end
      wait_end();
      go_idle();
   endtask

   task automatic test_reset_mid();
      int k; logic [9:0] seen;
      init_safe(10'($urandom_range(0, 1023)) | 10'h200, 1'b0, 1'b0);
      start = 1'b1;
      repeat (SETTLE + 2 + 5 * STEP) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || enter_cnt !== 0) begin
         errors++;
         $display("FAIL pre_reset: busy=%b enters=%0d want 1 0", busy, enter_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({guess, enter, busy, done, fail, tries} !== '0) begin
         errors++;
         $display("FAIL mid_reset: guess=%b enter=%b busy=%b done=%b fail=%b tries=%0d want all 0",
                  guess, enter, busy, done, fail, tries);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_enter(k, seen);
      vectors++;
      if (k !== enter_latency(pw)) begin
         errors++;
         $display("FAIL restart latency: got %0d want %0d", k, enter_latency(pw));
      end
      wait_end();
      check_success("reset_restart", 0);
      go_idle();
   endtask

   task automatic test_start_toggle();
      int k = 1;
      init_safe(10'b1010010011, 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      while (!enter && k < 1000) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         k++;
      end
      start = 1'b1;
      vectors++;
      if (k !== enter_latency(pw)) begin
         errors++;
         $display("FAIL toggle latency: got %0d want %0d", k, enter_latency(pw));
      end
      wait_end();
      repeat (3) @(negedge clk);
      check_success("start_toggle", 0);
      go_idle();
   endtask

   initial begin
      test_reset();
      test_search(10'b1010010011, "fixed_pw");
      test_search(10'd0, "zero_pw");
      test_random();
      test_lock_fail();
      test_inconsistent();
      test_reset_mid();
      test_start_toggle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
